mem_arbiter: RTL and testbench

Arbitrates the single shared 4-cycle pipelined main memory (`memory4c`) between the instruction-cache and data-cache miss FSMs. It replaces the fixed "I-cache-busy wins" mux with a registered grant state machine:
- holds ownership for a whole burst,
- tracks in-flight reads so returned words reach the requester that issued them,
- applies round-robin fairness when both caches request in the same cycle.

It sits between `iCache`/`dCache` and `memory4c` inside the memory interface.

---
 rtl/mem_arbiter_pkg.sv | 31 +++
 rtl/mem_arbiter_outstanding_ctr.sv | 49 ++++
 rtl/mem_arbiter.sv | 158 +++++++++++++++
 tb/tb_mem_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the I-cache / D-cache memory arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arbiter_pkg;

    // Arbiter states: IDLE between owners, GNT_x while a cache owns the
    // memory, DRAIN while the last owner's reads are still coming back.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GNT_I = 2'd1,
        ST_GNT_D = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    // Default read depth matches the 4-cycle memory so bursts run bubble-free.
    localparam int MAX_OUT_DEF = 4;
    localparam int CNT_W_DEF   = 3;

    function automatic owner_t other_owner(input owner_t o);
        if (o == OWN_I) begin
            return OWN_D;
        end
        return OWN_I;
    endfunction

endpackage

// File: rtl/mem_arbiter_outstanding_ctr.sv
// Counts reads issued to memory but not yet returned; saturates at MAX_OUT, never underflows.
// Latency: count updates on the clock after inc/dec; full/zero/underflow are combinational.
// Backpressure: o_full tells the arbiter to hold further reads (a same-cycle return frees a slot).
//
// Ports: i_inc (read accepted), i_dec (memory data valid), o_cnt (current count),
//        o_full (no room for another read this cycle), o_zero (nothing in flight),
//        o_underflow (a return arrived with nothing in flight; it is dropped).
module outstanding_ctr
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_full,
    output logic             o_zero,
    output logic             o_underflow
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;
    logic             w_dec_ok;
    logic             w_inc_ok;

    assign w_at_max    = (r_cnt == CNT_W'(MAX_OUT));
    assign o_zero      = (r_cnt == '0);
    assign o_full      = w_at_max & ~i_dec;
    assign o_underflow = i_dec & o_zero;
    assign o_cnt       = r_cnt;

    // A return with nothing in flight is ignored so the count stays at 0.
    assign w_dec_ok = i_dec & ~o_zero;
    assign w_inc_ok = i_inc & (~w_at_max | w_dec_ok);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (w_inc_ok && !w_dec_ok) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (!w_inc_ok && w_dec_ok) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one pipelined main memory between the I-cache and D-cache miss engines.
// Latency: grant one cycle after a request is seen in IDLE; accept/mem_*/data_vld are combinational.
// Backpressure: reads stall while MAX_OUT are in flight; the non-owner waits until the next IDLE.
//
// Ports: clk/rst_n; I-cache read request + address; D-cache read/write request, address, write data;
//        i_gnt/d_gnt ownership, i_accept/d_accept issue strobes, i_data_vld/d_data_vld return routing;
//        mem_en/mem_wr/mem_addr/mem_data_in memory drive, mem_data_valid memory return;
//        err_spurious sticky flag for a return seen with nothing outstanding.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int MAX_OUT = MAX_OUT_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_rd_req,
    input  logic [15:0] i_addr,
    input  logic        d_rd_req,
    input  logic        d_wr_req,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        i_gnt,
    output logic        d_gnt,
    output logic        i_accept,
    output logic        d_accept,
    output logic        i_data_vld,
    output logic        d_data_vld,
    output logic        mem_en,
    output logic        mem_wr,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_data_in,
    input  logic        mem_data_valid,
    output logic        err_spurious
);

    arb_state_t       r_state;
    arb_state_t       w_state_nxt;
    owner_t           r_owner;
    owner_t           w_owner_nxt;
    owner_t           r_last;
    owner_t           w_last_nxt;
    owner_t           w_pick;
    logic             r_err;

    logic             w_d_req;
    logic             w_rd_issue;
    logic [CNT_W-1:0] w_cnt;
    logic             w_full;
    logic             w_zero;
    logic             w_underflow;
    logic             w_last_return;

    assign w_d_req = d_rd_req | d_wr_req;

    outstanding_ctr #(
        .MAX_OUT (MAX_OUT),
        .CNT_W   (CNT_W)
    ) u_ctr (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_inc       (w_rd_issue),
        .i_dec       (mem_data_valid),
        .o_cnt       (w_cnt),
        .o_full      (w_full),
        .o_zero      (w_zero),
        .o_underflow (w_underflow)
    );

    // The final outstanding word returning this cycle lets DRAIN exit now.
    assign w_last_return = (w_cnt == CNT_W'(1)) & mem_data_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_owner <= OWN_I;
            r_last  <= OWN_D;   // so the I-cache wins the first tie
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
            if (w_underflow) begin
                r_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        w_pick      = OWN_I;
        case (r_state)
            ST_IDLE: begin
                if (i_rd_req && w_d_req) begin
                    w_pick = other_owner(r_last);
                end else if (w_d_req) begin
                    w_pick = OWN_D;
                end
                if (i_rd_req || w_d_req) begin
                    w_owner_nxt = w_pick;
                    w_last_nxt  = w_pick;
                    if (w_pick == OWN_I) begin
                        w_state_nxt = ST_GNT_I;
                    end else begin
                        w_state_nxt = ST_GNT_D;
                    end
                end
            end
            ST_GNT_I: begin
                if (!i_rd_req) begin
                    w_state_nxt = w_zero ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_GNT_D: begin
                if (!w_d_req) begin
                    w_state_nxt = w_zero ? ST_IDLE : ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (w_zero || w_last_return) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign i_gnt = (r_state == ST_GNT_I);
    assign d_gnt = (r_state == ST_GNT_D);

    // Writes ignore the read limit: they are fire-and-forget and win over a
    // simultaneous D-cache read.
    assign i_accept   = i_gnt & i_rd_req & ~w_full;
    assign d_accept   = d_gnt & ((d_rd_req & ~w_full) | d_wr_req);
    assign w_rd_issue = i_accept | (d_accept & ~d_wr_req);

    assign mem_en      = i_accept | d_accept;
    assign mem_wr      = d_accept & d_wr_req;
    assign mem_data_in = d_wdata;

    always_comb begin
        mem_addr = 16'h0000;
        case (r_state)
            ST_GNT_I: mem_addr = i_addr;
            ST_GNT_D: mem_addr = d_addr;
            default:  mem_addr = 16'h0000;
        endcase
    end

    assign i_data_vld   = mem_data_valid & (r_owner == OWN_I) & ~w_zero;
    assign d_data_vld   = mem_data_valid & (r_owner == OWN_D) & ~w_zero;
    assign err_spurious = r_err;

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int MAXO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_rd_req, d_rd_req, d_wr_req, mem_data_valid;
    logic [15:0] i_addr, d_addr, d_wdata;
    logic        i_gnt, d_gnt, i_accept, d_accept, i_data_vld, d_data_vld;
    logic        mem_en, mem_wr, err_spurious;
    logic [15:0] mem_addr, mem_data_in;

    mem_arbiter dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_rd_req       (i_rd_req),
        .i_addr         (i_addr),
        .d_rd_req       (d_rd_req),
        .d_wr_req       (d_wr_req),
        .d_addr         (d_addr),
        .d_wdata        (d_wdata),
        .i_gnt          (i_gnt),
        .d_gnt          (d_gnt),
        .i_accept       (i_accept),
        .d_accept       (d_accept),
        .i_data_vld     (i_data_vld),
        .d_data_vld     (d_data_vld),
        .mem_en         (mem_en),
        .mem_wr         (mem_wr),
        .mem_addr       (mem_addr),
        .mem_data_in    (mem_data_in),
        .mem_data_valid (mem_data_valid),
        .err_spurious   (err_spurious)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Memory model: absolute cycle numbers at which read data comes back.
    int lat = 4;
    int ret_q[$];
    bit inj_spur = 0;

    // Scoreboard of expected {i_data_vld, d_data_vld} for every memory return.
    logic [1:0] sb_q[$];

    // Reference model: who holds the memory (0 none, 1 I, 2 D, 3 waiting for
    // returns), who was served last, reads in flight and the owner of each.
    int sess, m_last, m_out;
    bit m_err;
    int tag_q[$];

    // Requester models.
    int          i_left = 0, d_left = 0;
    bit          d_wr_mode = 0, d_both = 0;
    logic [15:0] i_seq = 0, d_seq = 0;

    // Statistics for directed phases.
    int n_iacc, n_istall, n_ivld, n_dvld, n_rd, n_wr;
    logic [15:0] wr_addr, wr_data;
    int gnt_order[$];
    bit prev_ig = 0, prev_dg = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 40)
                $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        sess = 0; m_last = 2; m_out = 0; m_err = 0;
        tag_q.delete();
    endtask

    task automatic clear_stats();
        n_iacc = 0; n_istall = 0; n_ivld = 0; n_dvld = 0; n_rd = 0; n_wr = 0;
        wr_addr = 0; wr_data = 0;
        gnt_order.delete();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_i_gnt"},      i_gnt, 0);
        check({tag, "_d_gnt"},      d_gnt, 0);
        check({tag, "_i_accept"},   i_accept, 0);
        check({tag, "_d_accept"},   d_accept, 0);
        check({tag, "_i_data_vld"}, i_data_vld, 0);
        check({tag, "_d_data_vld"}, d_data_vld, 0);
        check({tag, "_mem_en"},     mem_en, 0);
        check({tag, "_mem_wr"},     mem_wr, 0);
        check({tag, "_mem_addr"},   mem_addr, 0);
        check({tag, "_err"},        err_spurious, 0);
    endtask

    // Drive inputs just after the rising edge.
    task automatic drive();
        int t;
        i_rd_req = (i_left > 0);
        d_wr_req = (d_left > 0) && d_wr_mode;
        d_rd_req = (d_left > 0) && (!d_wr_mode || d_both);
        i_addr   = 16'h1000 + i_seq;
        d_addr   = d_wr_mode ? 16'h0040 : (16'h2000 + d_seq);
        d_wdata  = d_wr_mode ? 16'hBEEF : (16'h1234 ^ d_seq);
        while (ret_q.size() > 0 && ret_q[0] < cyc) void'(ret_q.pop_front());
        mem_data_valid = 1'b0;
        if (ret_q.size() > 0 && ret_q[0] == cyc) begin
            void'(ret_q.pop_front());
            mem_data_valid = 1'b1;
        end else if (inj_spur) begin
            mem_data_valid = 1'b1;
        end
        inj_spur = 0;
        if (mem_data_valid) begin
            if (m_out > 0 && tag_q.size() > 0) begin
                t = tag_q.pop_front();
                sb_q.push_back(t == 1 ? 2'b10 : 2'b01);
            end else begin
                sb_q.push_back(2'b00);
            end
        end
    endtask

    // Sample at the falling edge, compare against the model, then advance it.
    task automatic observe();
        bit full, e_ig, e_dg, e_ia, e_da, e_rd, ret, ir, dq;
        logic [15:0] e_addr;
        ir   = i_rd_req;
        dq   = d_rd_req || d_wr_req;
        full = (m_out == MAXO) && !mem_data_valid;
        e_ig = (sess == 1);
        e_dg = (sess == 2);
        e_ia = e_ig && ir && !full;
        e_da = e_dg && (d_wr_req || (d_rd_req && !full));
        e_rd = e_ia || (e_da && !d_wr_req);
        e_addr = e_ig ? i_addr : (e_dg ? d_addr : 16'h0000);

        check("i_gnt", i_gnt, e_ig);
        check("d_gnt", d_gnt, e_dg);
        check("i_accept", i_accept, e_ia);
        check("d_accept", d_accept, e_da);
        check("mem_en", mem_en, e_ia || e_da);
        check("mem_wr", mem_wr, e_da && d_wr_req);
        check("mem_addr", mem_addr, e_addr);
        check("mem_data_in", mem_data_in, d_wdata);
        check("err_spurious", err_spurious, m_err);

        if (mem_en && !mem_wr) begin
            ret_q.push_back(cyc + lat);
            n_rd++;
        end
        if (mem_en && mem_wr) begin
            n_wr++; wr_addr = mem_addr; wr_data = mem_data_in;
        end
        if (i_accept && i_left > 0) begin i_left--; i_seq++; n_iacc++; end
        if (d_accept && d_left > 0) begin d_left--; d_seq++; end
        if (i_gnt && i_rd_req && !i_accept) n_istall++;
        if (i_data_vld) n_ivld++;
        if (d_data_vld) n_dvld++;
        if (i_gnt && !prev_ig) gnt_order.push_back(1);
        if (d_gnt && !prev_dg) gnt_order.push_back(2);
        prev_ig = i_gnt;
        prev_dg = d_gnt;

        if (e_rd) tag_q.push_back(e_ia ? 1 : 2);
        ret = mem_data_valid && (m_out > 0);
        if (mem_data_valid && m_out == 0) m_err = 1;
        case (sess)
            0: begin
                if (ir && dq) sess = (m_last == 1) ? 2 : 1;
                else if (ir) sess = 1;
                else if (dq) sess = 2;
                if (sess != 0) m_last = sess;
            end
            1: if (!ir) sess = (m_out == 0) ? 0 : 3;
            2: if (!dq) sess = (m_out == 0) ? 0 : 3;
            default: if (m_out - int'(ret) == 0) sess = 0;
        endcase
        m_out = m_out + int'(e_rd) - int'(ret);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        drive();
        @(negedge clk);
        observe();
    endtask

    task automatic run_quiet(input string name);
        int n = 0;
        while (!(i_left == 0 && d_left == 0 && ret_q.size() == 0 && sess == 0) && n < 400) begin
            step();
            n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL %s_timeout: still busy after %0d cycles, required idle", name, n);
            i_left = 0; d_left = 0;
        end
        step();
    endtask

    // Return monitor: pops one expectation per memory return.
    initial begin
        logic [1:0] e;
        forever begin
            @(negedge clk);
            if (mem_data_valid || i_data_vld || d_data_vld) begin
                if (sb_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL data_vld_unexpected: got %b%b expected no return", i_data_vld, d_data_vld);
                end else begin
                    e = sb_q.pop_front();
                    check("data_vld_route", {30'd0, i_data_vld, d_data_vld}, {30'd0, e});
                end
            end
        end
    end

    initial begin
        int n;
        rst_n = 0; i_rd_req = 0; d_rd_req = 0; d_wr_req = 0; mem_data_valid = 0;
        i_addr = 0; d_addr = 0; d_wdata = 0;
        model_reset();
        clear_stats();
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1;

        // Simultaneous requests: I first after reset, then D; next tie goes to I again.
        i_left = 3; d_left = 3;
        run_quiet("tie1");
        check("tie1_count", gnt_order.size(), 2);
        check("tie1_first", gnt_order.size() > 0 ? gnt_order[0] : 0, 1);
        check("tie1_second", gnt_order.size() > 1 ? gnt_order[1] : 0, 2);
        clear_stats();
        i_left = 2; d_left = 2;
        run_quiet("tie2");
        check("tie2_first", gnt_order.size() > 0 ? gnt_order[0] : 0, 1);

        // 8-word I burst at latency 4: no bubbles.
        clear_stats();
        i_left = 8;
        run_quiet("burst8");
        check("burst8_accepts", n_iacc, 8);
        check("burst8_stalls", n_istall, 0);
        check("burst8_returns", n_ivld, 8);

        // Write with read also asserted: only the write goes out.
        clear_stats();
        d_wr_mode = 1; d_both = 1; d_left = 1;
        run_quiet("write");
        check("write_count", n_wr, 1);
        check("write_addr", wr_addr, 16'h0040);
        check("write_data", wr_data, 16'hBEEF);
        check("write_no_reads", n_rd, 0);
        check("write_no_returns", n_dvld, 0);
        d_wr_mode = 0; d_both = 0;

        // Latency 6: four reads then two stall cycles, then one per return.
        clear_stats();
        lat = 6; i_left = 6;
        run_quiet("lat6");
        check("lat6_accepts", n_iacc, 6);
        check("lat6_stalls", n_istall, 2);
        check("lat6_returns", n_ivld, 6);
        lat = 4;

        // Spurious return in IDLE.
        clear_stats();
        inj_spur = 1;
        repeat (5) step();
        check("spur_flag_held", err_spurious, 1);
        check("spur_no_vld", n_ivld + n_dvld, 0);

        // Reset with three reads in flight.
        rst_n = 0;
        #1;
        model_reset();
        rst_n = 1;
        clear_stats();
        i_left = 8;
        n = 0;
        while (n_iacc < 3 && n < 50) begin step(); n++; end
        check("rst_pre_accepts", n_iacc, 3);
        @(posedge clk);
        #1;
        rst_n = 0; i_left = 0; i_rd_req = 0; mem_data_valid = 0;
        #1;
        check_all_zero("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1;
        clear_stats();
        run_quiet("late");
        check("late_no_ivld", n_ivld, 0);
        check("late_no_dvld", n_dvld, 0);
        check("late_err", err_spurious, 1);

        // Randomized traffic.
        for (int k = 0; k < 800; k++) begin
            if (i_left == 0 && $urandom_range(0, 3) == 0) i_left = $urandom_range(1, 8);
            if (d_left == 0 && $urandom_range(0, 3) == 0) begin
                d_wr_mode = ($urandom_range(0, 2) == 0);
                d_both    = d_wr_mode && ($urandom_range(0, 1) == 1);
                d_left    = d_wr_mode ? 1 : $urandom_range(1, 4);
            end
            if (m_out == 0 && ret_q.size() == 0 && $urandom_range(0, 49) == 0) inj_spur = 1;
            step();
        end
        run_quiet("random");
        check("final_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
